// File: rtl/demux_frame_driver.sv
// Serialises a 4-bit frame onto a 1-to-4 demux: {x1,x0} selects output s_idx, f carries word[idx].
// Each frame is followed by GAP_CYCLES idle cycles; frame_cnt counts completed frames.
module demux_frame_driver #(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_word,
  output logic       in_ready,
  output logic       x1,
  output logic       x0,
  output logic       f,
  output logic       busy,
  output logic       done,
  output logic [7:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t     state;
  logic [1:0] idx;
  logic [1:0] idx_next;
  logic [3:0] word;
  logic [3:0] gap_cnt;

  always_comb idx_next = idx + 2'd1;

  // Outputs are loaded one cycle ahead so they line up with the registered idx.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      word      <= '0;
      gap_cnt   <= '0;
      in_ready  <= 1'b1;
      x1        <= 1'b0;
      x0        <= 1'b0;
      f         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            word     <= in_word;
            idx      <= '0;
            state    <= SEND;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            {x1, x0} <= 2'b00;
            f        <= in_word[0];
            done     <= 1'b0;
          end
        end
        SEND: begin
          if (idx == 2'd3) begin
            frame_cnt <= frame_cnt + 8'd1;
            done      <= 1'b0;
            {x1, x0}  <= 2'b00;
            f         <= 1'b0;
            gap_cnt   <= '0;
            if (GAP_CYCLES > 0) begin
              state    <= GAP;
              busy     <= 1'b1;
              in_ready <= 1'b0;
            end else begin
              state    <= IDLE;
              busy     <= 1'b0;
              in_ready <= 1'b1;
            end
          end else begin
            idx      <= idx_next;
            {x1, x0} <= idx_next;
            f        <= word[idx_next];
            done     <= (idx_next == 2'd3);
          end
        end
        GAP: begin
          if (gap_cnt == 4'(GAP_CYCLES - 1)) begin
            state    <= IDLE;
            busy     <= 1'b0;
            in_ready <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/demux_frame_driver.md
DEMUX_FRAME_DRIVER -- requirements
Module: demux_frame_driver

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 1, meaning the number of idle cycles inserted after each frame; legal range 0..15.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1, meaning in_word holds a frame to send.
REQ-005 The block SHALL have port in_word, input, 4, the frame; bit i is the data destined for demux output s_i.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block accepts a frame this cycle.
REQ-007 The block SHALL have port x1, output, 1, the demux select MSB.
REQ-008 The block SHALL have port x0, output, 1, the demux select LSB.
REQ-009 The block SHALL have port f, output, 1, the demux data bit.
REQ-010 The block SHALL have port busy, output, 1, high while a frame or gap is in progress.
REQ-011 The block SHALL have port done, output, 1, a one-cycle pulse marking the last bit of a frame.
REQ-012 The block SHALL have port frame_cnt, output, 8, the count of completed frames.

Function
REQ-013 The block SHALL implement the states IDLE, SEND and GAP.
REQ-014 In IDLE, the block SHALL hold in_ready=1, busy=0, f=0 and {x1,x0}=00.
REQ-015 A rising edge with in_valid=1 and in_ready=1 SHALL capture in_word, set idx=0 and enter SEND.
REQ-016 In SEND, the block SHALL hold in_ready=0 and busy=1.
REQ-017 All outputs SHALL be registered; in SEND, {x1,x0}=idx and f=word[idx].
REQ-018 idx SHALL advance by 1 per cycle, so bits 0,1,2,3 appear on the 1st to 4th cycles after the accept edge.
REQ-019 done SHALL be 1 exactly during the SEND cycle with idx=3, and 0 otherwise.
REQ-020 frame_cnt SHALL increment by 1 at the edge that ends the idx=3 cycle, modulo 256 (255 wraps to 0).
REQ-021 After idx=3, the block SHALL enter GAP if GAP_CYCLES>0, otherwise IDLE.
REQ-022 In GAP, the block SHALL hold f=0, {x1,x0}=00, busy=1 and in_ready=0 for exactly GAP_CYCLES cycles, then enter IDLE.
REQ-023 With GAP_CYCLES=0, a frame presented while in IDLE SHALL be accepted on the first IDLE cycle.
REQ-024 The minimum frame period SHALL be 5+GAP_CYCLES cycles.
REQ-025 While in_ready=0, in_valid and in_word SHALL be ignored, and the captured word SHALL not change mid-frame.
REQ-026 A frame of 4'b0000 SHALL still occupy 4 SEND cycles, pulse done and count in frame_cnt.
REQ-027 in_valid held continuously SHALL produce back-to-back frames separated by GAP_CYCLES gap cycles plus 1 IDLE cycle.

Reset
REQ-028 rst=1 SHALL immediately, without waiting for clk, force state=IDLE, idx=0, and the captured word, x1, x0, f, busy, done and frame_cnt to 0.
REQ-029 in_ready SHALL be 1 during reset.
REQ-030 A reset asserted mid-SEND or mid-GAP SHALL discard the frame and SHALL not increment frame_cnt.
REQ-031 After rst deasserts, the first accept SHALL be possible at the next rising edge.

Verification
REQ-032 The bench SHALL cover single frame: GAP_CYCLES=1, accept in_word=4'b1010 -> cycles 1..4 show {x1,x0}/f = 00/0, 01/1, 10/0, 11/1; done=1 only in cycle 4; frame_cnt=1; one GAP cycle, then in_ready=1.
REQ-033 The bench SHALL cover back-to-back: GAP_CYCLES=0, in_valid held high with words 4'b1111 then 4'b0001 -> 5-cycle period; f sequence 1,1,1,1 then 1,0,0,0; frame_cnt=2.
REQ-034 The bench SHALL cover ignored input: in_valid=1 with changing in_word during SEND -> transmitted bits match the originally captured word and in_ready stays 0.
REQ-035 The bench SHALL cover reset mid-frame: assert rst asynchronously between edges during idx=2 -> outputs go to 0 before the next edge, frame_cnt unchanged at 0, in_ready=1.
REQ-036 The bench SHALL cover wrap: send 256 frames -> frame_cnt reads 255 after frame 255 and 0 after frame 256.
REQ-037 The bench SHALL cover downstream check: drive a 1-to-4 demux from x1, x0 and f -> each s_i pulses high exactly when in_word[i]=1, during its own SEND cycle.
